// File: rtl/mult_booth_iter.sv
// Iterative radix-4 Booth multiplier for MUL/MULH/MULHSU/MULHU/MULW.
// Latency: NSTEP/PPC cycles from accept to o_valid (word ops: ceil(NSTEP_W/PPC)).
// Backpressure: one op in flight, o_ready only in IDLE; result held in DONE until i_ready.
module mult_booth_iter #(
  parameter int XLEN = 64,
  parameter int PPC  = 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [1:0]      i_mode,
  input  logic            i_word,
  input  logic [XLEN-1:0] i_src1,
  input  logic [XLEN-1:0] i_src2,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_res
);

  localparam int EXT     = XLEN + 2;
  localparam int NSTEP   = EXT / 2;
  localparam int NSTEP_W = (XLEN / 2 + 2) / 2;
  localparam int LIM_W   = ((NSTEP_W + PPC - 1) / PPC) * PPC;
  localparam int AW      = 2 * EXT;
  localparam int CW      = $clog2(NSTEP + PPC + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [AW-1:0]   x_q, x_d;       // multiplicand, pre-shifted to the current step weight
  logic [EXT:0]    y_q, y_d;       // multiplier with y[-1]=0 appended, consumed 2 bits/step
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      mode_q;
  logic            word_q;
  logic [XLEN-1:0] res_q, res_d;
  logic [2*XLEN-1:0] prod;
  logic [EXT-1:0]  x_ext, y_ext;
  logic            s1_sgn, s2_sgn, last_step;
  logic            unused_acc_hi;

  assign o_ready = (state_q == IDLE);
  assign o_valid = (state_q == DONE);
  assign o_res   = res_q;

  // Operand extension: word ops take the low 32 bits sign-extended, otherwise per-mode signedness.
  always_comb begin
    s1_sgn = (i_mode != 2'b11);
    s2_sgn = ~i_mode[1];
    if (i_word) begin
      x_ext = {{(EXT-32){i_src1[31]}}, i_src1[31:0]};
      y_ext = {{(EXT-32){i_src2[31]}}, i_src2[31:0]};
    end else begin
      x_ext = {{2{s1_sgn & i_src1[XLEN-1]}}, i_src1};
      y_ext = {{2{s2_sgn & i_src2[XLEN-1]}}, i_src2};
    end
  end

  // PPC Booth steps per cycle; each step reads the low triplet then shifts operands by 2 bits.
  always_comb begin
    acc_d = acc_q;
    x_d   = x_q;
    y_d   = y_q;
    for (int j = 0; j < PPC; j++) begin
      case (y_d[2:0])
        3'b001, 3'b010: acc_d = acc_d + x_d;
        3'b011:         acc_d = acc_d + (x_d << 1);
        3'b100:         acc_d = acc_d - (x_d << 1);
        3'b101, 3'b110: acc_d = acc_d - x_d;
        default:        acc_d = acc_d;
      endcase
      x_d = x_d << 2;
      y_d = y_d >> 2;
    end
    cnt_d     = cnt_q + CW'(PPC);
    last_step = (state_q == BUSY) &&
                (cnt_d == (word_q ? CW'(LIM_W) : CW'(NSTEP)));
  end

  // Result select from the final accumulator value.
  always_comb begin
    prod = acc_d[2*XLEN-1:0];
    if (word_q)
      res_d = {{(XLEN-32){prod[31]}}, prod[31:0]};
    else if (mode_q == 2'b00)
      res_d = prod[XLEN-1:0];
    else
      res_d = prod[2*XLEN-1:XLEN];
  end

  assign unused_acc_hi = ^acc_d[AW-1:2*XLEN];

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; flush overrides everything.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_valid) state_d = BUSY;
      BUSY:    if (last_step) state_d = DONE;
      DONE:    if (i_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (i_flush) state_d = IDLE;
  end

  // Datapath: load on accept, accumulate while busy, capture result on the final step.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
      cnt_q  <= '0;
      mode_q <= '0;
      word_q <= 1'b0;
      res_q  <= '0;
    end else if (!i_flush) begin
      if (state_q == IDLE && i_valid) begin
        acc_q  <= '0;
        x_q    <= {{EXT{x_ext[EXT-1]}}, x_ext};
        y_q    <= {y_ext, 1'b0};
        cnt_q  <= '0;
        mode_q <= i_mode;
        word_q <= i_word;
      end else if (state_q == BUSY) begin
        acc_q <= acc_d;
        x_q   <= x_d;
        y_q   <= y_d;
        cnt_q <= cnt_d;
        if (last_step) res_q <= res_d;
      end
    end
  end

endmodule

// File: tb/tb_mult_booth_iter.sv
module tb_mult_booth_iter;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_flush;
  logic        i_valid;
  logic [1:0]  i_mode;
  logic        i_word;
  logic [63:0] i_src1, i_src2;
  logic        i_ready;
  logic        o_ready0, o_valid0, o_ready11, o_valid11;
  logic [63:0] o_res0, o_res11;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 i_clk = ~i_clk;

  mult_booth_iter #(.XLEN(64), .PPC(1)) u_dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush), .i_valid(i_valid),
    .o_ready(o_ready0), .i_mode(i_mode), .i_word(i_word), .i_src1(i_src1),
    .i_src2(i_src2), .o_valid(o_valid0), .i_ready(i_ready), .o_res(o_res0)
  );

  mult_booth_iter #(.XLEN(64), .PPC(11)) u_dut11 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush), .i_valid(i_valid),
    .o_ready(o_ready11), .i_mode(i_mode), .i_word(i_word), .i_src1(i_src1),
    .i_src2(i_src2), .o_valid(o_valid11), .i_ready(i_ready), .o_res(o_res11)
  );

  typedef struct {
    logic [1:0]  mode;
    logic        word;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge i_clk);
    #1;
  endtask

  // Wait for PPC=1 result; lat counts edges from the accept edge.
  task automatic wait_valid0(output int lat, output logic [63:0] res);
    lat = 100;
    res = 'x;
    for (int c = 1; c <= 100; c++) begin
      step();
      if (o_valid0) begin
        lat = c;
        res = o_res0;
        break;
      end
    end
  endtask

  task automatic issue(input logic [1:0] mode, input logic word,
                       input logic [63:0] a, input logic [63:0] b);
    i_mode  = mode;
    i_word  = word;
    i_src1  = a;
    i_src2  = b;
    i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    i_src1  = '1;
    i_src2  = '1;
  endtask

  // Runs one op through both instances and checks results and latencies.
  task automatic run_vec(input vec_t v);
    int l0, l1;
    logic [63:0] r0, r1;
    bit s0, s1;
    int exp0, exp1;
    exp0 = v.word ? 17 : 33;
    exp1 = v.word ? 2 : 3;
    s0 = 0; s1 = 0; l0 = 100; l1 = 100; r0 = 'x; r1 = 'x;
    check({v.name, "_ready"}, {63'd0, o_ready0 & o_ready11}, 64'd1);
    issue(v.mode, v.word, v.a, v.b);
    for (int c = 1; c <= 100 && !(s0 && s1); c++) begin
      step();
      if (!s0 && o_valid0)  begin s0 = 1; l0 = c; r0 = o_res0;  end
      if (!s1 && o_valid11) begin s1 = 1; l1 = c; r1 = o_res11; end
    end
    check({v.name, "_res_ppc1"}, r0, v.exp);
    check({v.name, "_lat_ppc1"}, 64'(l0), 64'(exp0));
    check({v.name, "_res_ppc11"}, r1, v.exp);
    check({v.name, "_lat_ppc11"}, 64'(l1), 64'(exp1));
    step();
  endtask

  initial begin
    int lat;
    logic [63:0] r;
    bit seen;
    vec_t v;

    vecs[0]  = '{2'b00, 1'b0, 64'd3, 64'd5, 64'd15, "mul_3x5"};
    vecs[1]  = '{2'b00, 1'b0, 64'hFFFFFFFFFFFFFFF9, 64'd3, 64'hFFFFFFFFFFFFFFEB, "mul_m7x3"};
    vecs[2]  = '{2'b01, 1'b0, 64'h8000000000000000, 64'h8000000000000000, 64'h4000000000000000, "mulh_min"};
    vecs[3]  = '{2'b11, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFE, "mulhu_ones"};
    vecs[4]  = '{2'b10, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, "mulhsu_m1"};
    vecs[5]  = '{2'b00, 1'b1, 64'h000000007FFFFFFF, 64'd2, 64'hFFFFFFFFFFFFFFFE, "mulw_ovf"};
    vecs[6]  = '{2'b01, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'd0, "mulh_m1m1"};
    vecs[7]  = '{2'b01, 1'b0, 64'hFFFFFFFFFFFFFFFE, 64'd3, 64'hFFFFFFFFFFFFFFFF, "mulh_m2x3"};
    vecs[8]  = '{2'b11, 1'b0, 64'h8000000000000000, 64'd2, 64'd1, "mulhu_2p63x2"};
    vecs[9]  = '{2'b01, 1'b0, 64'h0000000100000000, 64'h0000000100000000, 64'd1, "mulh_2p32sq"};
    vecs[10] = '{2'b10, 1'b0, 64'h8000000000000000, 64'd2, 64'hFFFFFFFFFFFFFFFF, "mulhsu_min"};
    vecs[11] = '{2'b01, 1'b1, 64'hDEADBEEF00000003, 64'h12345678FFFFFFFB, 64'hFFFFFFFFFFFFFFF1, "mulw_upper"};
    vecs[12] = '{2'b11, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'd2, 64'd1, "mulhu_onesx2"};
    vecs[13] = '{2'b00, 1'b0, 64'h123456789ABCDEF0, 64'h10, 64'h23456789ABCDEF00, "mul_shift"};
    vecs[14] = '{2'b00, 1'b1, 64'h0000000000010000, 64'h0000000000010000, 64'd0, "mulw_wrap"};
    vecs[15] = '{2'b10, 1'b0, 64'd5, 64'h8000000000000000, 64'd2, "mulhsu_5x2p63"};

    i_rst_n = 1'b0; i_flush = 1'b0; i_valid = 1'b0; i_mode = '0; i_word = 1'b0;
    i_src1 = '0; i_src2 = '0; i_ready = 1'b1;
    #22;
    check("rst_ready", {63'd0, o_ready0}, 64'd1);
    check("rst_valid", {63'd0, o_valid0}, 64'd0);
    check("rst_res", o_res0, 64'd0);
    i_rst_n = 1'b1;
    step();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Async reset in the middle of an op.
    issue(2'b00, 1'b0, 64'h0000123400005678, 64'h00009ABC0000DEF0);
    repeat (9) step();
    i_rst_n = 1'b0;
    #1;
    check("amid_rst_valid", {63'd0, o_valid0}, 64'd0);
    check("amid_rst_ready", {63'd0, o_ready0}, 64'd1);
    check("amid_rst_res", o_res0, 64'd0);
    check("amid_rst_res11", o_res11, 64'd0);
    #3;
    i_rst_n = 1'b1;
    step();
    v = '{2'b00, 1'b0, 64'd3, 64'd5, 64'd15, "post_rst_mul"};
    run_vec(v);

    // Backpressure in DONE with a competing request.
    i_ready = 1'b0;
    issue(2'b00, 1'b0, 64'd6, 64'd7);
    wait_valid0(lat, r);
    check("bp_lat", 64'(lat), 64'd33);
    i_mode = 2'b00; i_word = 1'b0; i_src1 = 64'd100; i_src2 = 64'd200; i_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check("bp_hold_valid", {63'd0, o_valid0}, 64'd1);
      check("bp_hold_res", o_res0, 64'd42);
      check("bp_hold_ready", {63'd0, o_ready0}, 64'd0);
      step();
    end
    i_ready = 1'b1;
    step();
    check("bp_rel_valid", {63'd0, o_valid0}, 64'd0);
    check("bp_rel_ready", {63'd0, o_ready0}, 64'd1);
    check("bp_rel_res_hold", o_res0, 64'd42);
    step();
    i_valid = 1'b0;
    check("bp_accept_busy", {63'd0, o_ready0}, 64'd0);
    wait_valid0(lat, r);
    check("bp_next_lat", 64'(lat), 64'd33);
    check("bp_next_res", r, 64'd20000);
    step();

    // Flush mid-op, then an immediate back-to-back op.
    issue(2'b00, 1'b0, 64'd9, 64'd9);
    seen = 0;
    for (int c = 1; c < 20; c++) begin
      step();
      if (o_valid0) seen = 1;
    end
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    check("fl_valid", {63'd0, o_valid0}, 64'd0);
    check("fl_ready", {63'd0, o_ready0}, 64'd1);
    check("fl_res_hold", o_res0, 64'd20000);
    for (int c = 0; c < 20; c++) begin
      step();
      if (o_valid0) seen = 1;
    end
    check("fl_no_valid", {63'd0, seen}, 64'd0);
    v = '{2'b01, 1'b0, 64'h8000000000000000, 64'h8000000000000000, 64'h4000000000000000, "fl_next"};
    run_vec(v);

    // Flush coincident with accept discards the request.
    i_mode = 2'b00; i_word = 1'b0; i_src1 = 64'd11; i_src2 = 64'd13;
    i_valid = 1'b1; i_flush = 1'b1;
    step();
    i_valid = 1'b0; i_flush = 1'b0;
    check("fla_ready", {63'd0, o_ready0}, 64'd1);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (o_valid0) seen = 1;
    end
    check("fla_no_valid", {63'd0, seen}, 64'd0);

    // Flush while a result is held in DONE.
    i_ready = 1'b0;
    issue(2'b00, 1'b0, 64'd2, 64'd2);
    wait_valid0(lat, r);
    check("fld_res", r, 64'd4);
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    i_ready = 1'b1;
    check("fld_valid", {63'd0, o_valid0}, 64'd0);
    check("fld_ready", {63'd0, o_ready0}, 64'd1);
    check("fld_res_hold", o_res0, 64'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_booth_iter.md
Name: mult_booth_iter

Overview:
- Iterative radix-4 Booth multiplier for the EXU, the sequential successor of the combinational 66-bit Booth/Wallace multiplier.
- Covers all RV64M multiply ops: MUL, MULH, MULHSU, MULHU, MULW.
- Retires PPC Booth partial products per cycle, trading latency for area.
- Valid/ready handshake on both sides, pipeline flush, and early termination for word ops.

Parameters:
- XLEN, 64, operand/result width; must be even.
- PPC, 1, Booth partial products accumulated per cycle; must divide NSTEP (XLEN=64 legal: 1, 3, 11).
- Derived: EXT=XLEN+2 (extended operand width); NSTEP=EXT/2 (33); NSTEP_W=(XLEN/2+2)/2 (17).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_flush  in  1  kill in-flight op and any held result.
- i_valid  in  1  request valid.
- o_ready  out  1  block can accept a request (state IDLE).
- i_mode  in  2  00 MUL (low), 01 MULH s*s, 10 MULHSU s*u, 11 MULHU u*u.
- i_word  in  1  32-bit word op (MULW); forces low-half behaviour regardless of i_mode.
- i_src1  in  XLEN  multiplicand (rs1).
- i_src2  in  XLEN  multiplier (rs2).
- o_valid  out  1  result valid.
- i_ready  in  1  consumer accepts the result.
- o_res  out  XLEN  result.

Behaviour:
- Clocking/reset: one clock i_clk; reset i_rst_n asynchronous active-low. Reset state: IDLE, o_ready=1, o_valid=0, o_res=0, accumulator and counter 0.
- States: IDLE, BUSY, DONE.
- IDLE -> BUSY on i_valid&&o_ready (accept edge):
  - Latch the extended operands. src1 extends to EXT bits, sign-extended if signed for the mode (MUL/MULH/MULHSU signed, MULHU unsigned), else zero.
  - src2 extends the same way (signed only for MUL/MULH).
  - Word op: both sources use bits [31:0] sign-extended to EXT.
  - Latch the mode; clear the accumulator; step counter = 0.
- BUSY, each cycle:
  - Apply PPC Booth steps k = cnt..cnt+PPC-1, using multiplier triplet {y[2k+1], y[2k], y[2k-1]} with y[-1]=0.
  - Digit maps to 0, +x, +2x, -x, -2x. Each partial product is added to the 2*EXT accumulator weighted by 4^k, with correct sign extension (two's complement, modulo 2^(2*EXT)).
  - cnt += PPC.
- BUSY -> DONE when cnt reaches NSTEP, or ceil(NSTEP_W/PPC)*PPC for word ops (early termination).
  - Latency: for XLEN=64, PPC=1, o_valid is high 33 cycles after the accept edge (17 for MULW).
- DONE: o_valid=1; o_res is valid and stable until the handshake.
  - o_res select:
    - MUL: product[XLEN-1:0].
    - MULH/MULHSU/MULHU: product[2*XLEN-1:XLEN].
    - Word: sign-extend product[31:0].
  - o_res is registered and updates on the BUSY->DONE edge; it holds its last value after the handshake.
- DONE -> IDLE on o_valid&&i_ready. No new accept in that same cycle (o_ready=0 in DONE); the next accept is possible the following cycle.
- i_valid ignored while not IDLE. Operands need only be stable at the accept edge.
- i_flush (synchronous, highest priority):
  - Any state -> IDLE next edge; o_valid=0 next cycle; result dropped; o_res keeps its old value.
  - Flush coincident with an accept: the request is discarded.
  - Flush coincident with a DONE handshake: IDLE either way; the consumer saw the result.
- Async reset mid-operation: immediate return to reset state; no result emitted.
- Arithmetic: all results bit-exact to the RV64M definition, including corner cases:
  - MULH(-2^63, -2^63) = 0x4000000000000000.
  - MULHSU with negative rs1.
  - MULHU(all ones, all ones) = 0xFFFFFFFFFFFFFFFE.

Test Plan:
- Reset mid-BUSY: start MUL, assert i_rst_n=0 at cycle 10 -> o_valid=0, o_ready=1, o_res=0 immediately; release, new MUL 3*5 -> o_res=15 after 33 cycles.
- Signed corners:
  - MULH src1=src2=0x8000000000000000 -> 0x4000000000000000.
  - MUL -7*3 -> 0xFFFFFFFFFFFFFFEB.
  - MULHU src1=src2=0xFFFFFFFFFFFFFFFF -> 0xFFFFFFFFFFFFFFFE.
  - MULHSU src1=-1, src2=0xFFFFFFFFFFFFFFFF -> 0xFFFFFFFFFFFFFFFF.
- Word op: MULW src1=0x00000000_7FFFFFFF, src2=2 -> o_res=0xFFFFFFFFFFFFFFFE; o_valid exactly 17 cycles after accept (PPC=1).
- Backpressure: hold i_ready=0 for 5 cycles in DONE -> o_valid and o_res stable; i_valid asserted meanwhile is not accepted (o_ready=0); release -> IDLE next cycle, then accept.
- Flush: MUL accepted, i_flush at cycle 20 -> IDLE next cycle, no o_valid ever for that op; back-to-back next op gives correct result.
- Parameter sweep: PPC=3 and PPC=11 with 10k random ops in each mode vs reference model -> all match; latency 11 and 3 cycles (MULW 6 and 2).
